// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone classic read/write master:
// FSM state encodings, bus widths and the default timeout.
package wb_master_pkg;

  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  // Bus cycles allowed in BUS before the optional timeout aborts the access
  localparam logic [15:0] C_TIMEOUT_DEFAULT = 16'd1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_master_rw_timeout_cnt.sv
// Bus-cycle timeout counter for wb_master_rw. Cleared when a command is
// accepted, counts every cycle spent in BUS, and raises o_tc during the
// C_TIMEOUT-th BUS cycle so the FSM can abort on that cycle's edge.
module wb_timeout_cnt #(
  parameter int unsigned C_TIMEOUT   = 1000,
  parameter int unsigned C_TIMEOUT_W = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [C_TIMEOUT_W-1:0] C_LAST = C_TIMEOUT_W'(C_TIMEOUT - 1);

  logic [C_TIMEOUT_W-1:0] r_cnt;

  // Count BUS cycles; restart on each accepted command and stop at the last count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_LAST)) begin
      r_cnt <= r_cnt + C_TIMEOUT_W'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/wb_master_rw.sv
// Wishbone classic single-access master bridging a valid/ready command
// channel to one bus cycle and returning a valid/ready response.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort silent bus cycles
// after C_TIMEOUT BUS cycles (reported as err + timeout).
module wb_master_rw
  import wb_master_pkg::*;
#(
  parameter int unsigned C_TIMEOUT   = 32'(C_TIMEOUT_DEFAULT),
  parameter int unsigned C_TIMEOUT_W = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  // command channel
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  // response channel
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  // Wishbone master
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  state_t              r_state;
  logic                r_cyc;
  logic                r_we;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_wb_dat;
  logic                r_rsp_valid;
  logic [WB_DAT_W-1:0] r_rsp_dat;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  logic                w_cmd_fire;
  logic                w_in_bus;
  logic                w_tc;

  // Ready is gated by reset so it reads 0 while reset is held
  assign cmd_ready_o = (r_state == ST_IDLE) && !wb_rst_i;
  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_in_bus    = (r_state == ST_BUS);

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(
    .C_TIMEOUT   (C_TIMEOUT),
    .C_TIMEOUT_W (C_TIMEOUT_W)
  ) u_timeout (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_cmd_fire),
    .i_en  (w_in_bus),
    .o_tc  (w_tc)
  );
`else
  // No timeout: BUS waits for the slave indefinitely
  assign w_tc = 1'b0;
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(C_TIMEOUT), 32'(C_TIMEOUT_W)};
`endif

  // Command/bus/response FSM; all bus and response outputs are registered
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state       <= ST_IDLE;
      r_cyc         <= 1'b0;
      r_we          <= 1'b0;
      r_sel         <= '0;
      r_adr         <= '0;
      r_wb_dat      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_we     <= cmd_we_i;
            r_sel    <= cmd_sel_i;
            r_adr    <= cmd_adr_i;
            r_wb_dat <= cmd_we_i ? cmd_dat_i : '0;
            r_cyc    <= 1'b1;
            r_state  <= ST_BUS;
          end
        end
        ST_BUS: begin
          // err beats ack; either beats a timeout on the same edge
          if (wb_err_i) begin
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_cyc         <= 1'b0;
            r_state       <= ST_RESP;
          end else if (wb_ack_i) begin
            r_rsp_dat     <= r_we ? '0 : wb_dat_i;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_cyc         <= 1'b0;
            r_state       <= ST_RESP;
          end else if (w_tc) begin
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_cyc         <= 1'b0;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign wb_we_o       = r_we;
  assign wb_sel_o      = r_sel;
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_wb_dat;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_wb_master_rw.sv
// Scoreboard bench for wb_master_rw: stimulus pushes expected bus and
// response entries; a negedge process plays the slave and checks outputs.
module tb_wb_master_rw;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  always #5 clk = ~clk;

  wb_master_rw #(.C_TIMEOUT(8), .C_TIMEOUT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // slave modes
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wbdat;
    int          lat;
    int          mode;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t cur;
  logic have_cur = 1'b0;
  int   sl_cnt = 0;
  logic ack_pend = 1'b0;

  int total = 0;
  int bad = 0;
  time t_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model and response monitor, both on the falling edge
  always @(negedge clk) begin
    if (wb_rst_i) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      sl_cnt   = 0;
      ack_pend = 1'b0;
      have_cur = 1'b0;
    end else begin
      chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      chk("cyc_outside_bus", wb_cyc_o & (cmd_ready_o | rsp_valid_o), 0);
      if (ack_pend) begin
        chk("rsp_latency", rsp_valid_o, 1);
        chk("cyc_drop_after_term", wb_cyc_o, 0);
        ack_pend = 1'b0;
      end
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid_o, 0);
        end else begin
          chk("rsp_dat", rsp_dat_o, rsp_q[0].dat);
          chk("rsp_err", rsp_err_o, rsp_q[0].err);
          chk("rsp_to", rsp_timeout_o, rsp_q[0].to);
          chk("ready_in_resp", cmd_ready_o, 0);
          if (rsp_ready_i) begin
            $display("rsp dat=%h err=%b to=%b t=%0t", rsp_dat_o, rsp_err_o, rsp_timeout_o, $time);
            void'(rsp_q.pop_front());
          end
        end
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      if (wb_cyc_o) begin
        if (sl_cnt == 0) begin
          if (bus_q.size() == 0) chk("unexpected_cyc", wb_cyc_o, 0);
          else begin
            cur = bus_q.pop_front();
            have_cur = 1'b1;
          end
        end
        sl_cnt++;
        if (have_cur) begin
          chk("wb_adr", wb_adr_o, cur.adr);
          chk("wb_we", wb_we_o, cur.we);
          chk("wb_sel", wb_sel_o, cur.sel);
          chk("wb_dat_o", wb_dat_o, cur.wbdat);
          if (sl_cnt == cur.lat && cur.mode != M_SILENT) begin
            wb_ack_i = (cur.mode == M_ACK) || (cur.mode == M_BOTH);
            wb_err_i = (cur.mode == M_ERR) || (cur.mode == M_BOTH);
            wb_dat_i = cur.rdata;
            ack_pend = 1'b1;
          end
        end
      end else begin
        sl_cnt   = 0;
        have_cur = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one command and return just after the accepting edge
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    int n = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept_timeout", (n < 50) ? 1 : 0, 1);
    tick();
    cmd_valid_i = 1'b0;
    t_acc = $time;
    $display("cmd we=%b adr=%h dat=%h sel=%h t=%0t", we, adr, dat, sel, t_acc);
  endtask

  task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_wbdat, input int lat,
                      input int mode, input logic [31:0] rdata, input logic push_rsp,
                      input logic [31:0] e_dat, input logic e_err, input logic e_to);
    bus_t b;
    rsp_t r;
    b.we = we; b.adr = adr; b.sel = sel; b.wbdat = exp_wbdat;
    b.lat = lat; b.mode = mode; b.rdata = rdata;
    bus_q.push_back(b);
    if (push_rsp) begin
      r.dat = e_dat; r.err = e_err; r.to = e_to;
      rsp_q.push_back(r);
    end
    send(we, adr, dat, sel);
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || wb_cyc_o || rsp_valid_o) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", rsp_q.size(), 0);
  endtask

  // Abort the current bus cycle with reset, between clock edges
  task automatic abort_by_reset();
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("rst_async_cyc", wb_cyc_o, 0);
    chk("rst_async_stb", wb_stb_o, 0);
    chk("rst_async_we", wb_we_o, 0);
    chk("rst_ready_low", cmd_ready_o, 0);
    bus_q.delete();
    tick();
    tick();
    wb_rst_i = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready_o, 1);
    tick();
    chk("ready_1cyc_after_release", cmd_ready_o, 1);
    chk("no_rsp_after_abort", rsp_valid_o, 0);
    repeat (4) tick();
    chk("no_rsp_after_abort_late", rsp_valid_o, 0);
  endtask

  initial begin
    time t_prev;
    int  n;

    // reset values
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_wbdat", wb_dat_o, 0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_to", rsp_timeout_o, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("ready_first_cycle", cmd_ready_o, 1);
    tick();

    // write, ack on 2nd BUS cycle
    rsp_ready_i = 1'b1;
    xact(1'b1, 32'h0000_0000, 32'hFFFF_EEEE, 4'hF, 32'hFFFF_EEEE, 2, M_ACK, 32'h0,
         1'b1, 32'h0, 1'b0, 1'b0);
    drain();

    // read with the response held off for 5 cycles
    rsp_ready_i = 1'b0;
    xact(1'b0, 32'h0000_0004, 32'h1111_1111, 4'hF, 32'h0, 1, M_ACK, 32'hEEEE_EEEE,
         1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("hold_rsp_seen", rsp_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_ready_low", cmd_ready_o, 0);
      chk("hold_dat", rsp_dat_o, 32'hEEEE_EEEE);
    end
    rsp_ready_i = 1'b1;
    drain();

    // ack and err together -> err, data zeroed
    xact(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h0, 1, M_BOTH, 32'h1234_5678,
         1'b1, 32'h0, 1'b1, 1'b0);
    drain();

    // err-only write
    xact(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 32'hCAFE_F00D, 2, M_ERR, 32'h0,
         1'b1, 32'h0, 1'b1, 1'b0);
    drain();

    // slow read, partial byte lanes
    xact(1'b0, 32'h0000_0100, 32'h2222_2222, 4'h3, 32'h0, 3, M_ACK, 32'hA5A5_5A5A,
         1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0);
    drain();

    // silent slave
`ifdef WB_MASTER_TIMEOUT_EN
    xact(1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h0, 0, M_SILENT, 32'h0,
         1'b1, 32'h0, 1'b1, 1'b1);
    n = 0;
    while (wb_cyc_o && n < 50) begin
      n++;
      tick();
    end
    chk("timeout_bus_cycles", n, 8);
    drain();
`else
    xact(1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h0, 0, M_SILENT, 32'h0,
         1'b0, 32'h0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (wb_cyc_o) n++;
      tick();
    end
    chk("no_timeout_cyc_held", n, 100);
    abort_by_reset();
`endif

    // reset mid-BUS on a write
    xact(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hF, 32'h5555_AAAA, 0, M_SILENT, 32'h0,
         1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    abort_by_reset();

    // back-to-back, immediate ack
    rsp_ready_i = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      we = k[0];
      a  = 32'h0000_1000 + 32'(k * 4);
      d  = 32'h0BAD_0000 + 32'(k);
      xact(we, a, d, 4'hF, we ? d : 32'h0, 1, M_ACK, 32'h7700_0000 + 32'(k),
           1'b1, we ? 32'h0 : 32'h7700_0000 + 32'(k), 1'b0, 1'b0);
      if (k > 0) chk("b2b_spacing", 32'(t_acc - t_prev), 32'd30);
      t_prev = t_acc;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
